// File: rtl/video_fetch_sched.sv
// Text-mode video fetch scheduler: per 16-pixel slot, fetches two character codes and their glyph
// rows over a shared read port and hands the assembled slot to the dot generator.
module video_fetch_sched #(
   parameter int unsigned H_SLOTS_VIS   = 40,
   parameter int unsigned H_SLOTS_TOTAL = 50,
   parameter int unsigned V_LINES_VIS   = 200,
   parameter int unsigned V_LINES_TOTAL = 260
) (
   input  logic        pixel_clk_i,
   input  logic        reset_i,
   input  logic        charset_i,
   input  logic        underrun_clr_i,
   output logic        rd_req_o,
   output logic        rd_space_o,
   output logic [10:0] rd_addr_o,
   input  logic        rd_ack_i,
   input  logic [7:0]  rd_data_i,
   output logic        video_latch_o,
   output logic [15:0] pixels_o,
   output logic [1:0]  reverse_o,
   output logic        display_en_o,
   output logic        frame_o,
   output logic        underrun_o
);

   localparam int unsigned SW = (H_SLOTS_TOTAL > 1) ? $clog2(H_SLOTS_TOTAL) : 1;
   localparam int unsigned LW = (V_LINES_TOTAL > 8) ? $clog2(V_LINES_TOTAL) : 3;
   localparam logic [SW-1:0] SlotLast = SW'(H_SLOTS_TOTAL - 1);
   localparam logic [SW-1:0] SlotVis  = SW'(H_SLOTS_VIS);
   localparam logic [LW-1:0] LineLast = LW'(V_LINES_TOTAL - 1);
   localparam logic [LW-1:0] LineVis  = LW'(V_LINES_VIS);

   typedef enum logic [2:0] {StIdle, StChar0, StChar1, StGlyph0, StGlyph1, StDone} state_e;

   state_e          state_q, state_d;
   logic [3:0]      pix_q;
   logic [SW-1:0]   slot_q, t_slot;
   logic [LW-1:0]   line_q, t_line;
   logic [10:0]     vaddr_q, row_base_q, char_addr_q, new_base, fetch_addr;
   logic [2:0]      tline_q;
   logic [7:0]      char0_q, char1_q, glyph0_q, glyph1_q;
   logic            vis_q, t_vis, slot_start, ack_ok;

   assign video_latch_o = (pix_q == 4'hF);
   assign slot_start    = (pix_q == 4'h0);
   // Requests are withdrawn on the latch clock so a late grant cannot race the underrun path.
   assign rd_req_o = (state_q inside {StChar0, StChar1, StGlyph0, StGlyph1}) && !video_latch_o;
   assign ack_ok   = rd_ack_i && rd_req_o;

   // Target is the slot that follows the current one; its data is latched at the end of this slot.
   always_comb begin
      t_slot = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
      t_line = line_q;
      if (slot_q == SlotLast) begin
         t_line = (line_q == LineLast) ? '0 : line_q + 1'b1;
      end
      t_vis    = (t_slot < SlotVis) && (t_line < LineVis);
      new_base = row_base_q;
      if (t_line == '0) begin
         new_base = '0;
      end else if (t_line[2:0] == 3'd0) begin
         new_base = row_base_q + 11'd80;
      end
      fetch_addr = (t_slot == '0) ? new_base : vaddr_q;
   end

   always_comb begin
      state_d    = state_q;
      rd_space_o = 1'b0;
      rd_addr_o  = '0;
      unique case (state_q)
         StIdle: begin
            if (slot_start) state_d = t_vis ? StChar0 : StDone;
         end
         StChar0: begin
            rd_addr_o = char_addr_q;
            if (ack_ok) state_d = StChar1;
         end
         StChar1: begin
            rd_addr_o = char_addr_q + 11'd1;
            if (ack_ok) state_d = StGlyph0;
         end
         StGlyph0: begin
            rd_space_o = 1'b1;
            rd_addr_o  = {charset_i, char0_q[6:0], tline_q};
            if (ack_ok) state_d = StGlyph1;
         end
         StGlyph1: begin
            rd_space_o = 1'b1;
            rd_addr_o  = {charset_i, char1_q[6:0], tline_q};
            if (ack_ok) state_d = StDone;
         end
         StDone: ;
         default: state_d = StIdle;
      endcase
      if (video_latch_o) state_d = StIdle;
   end

   always_ff @(posedge pixel_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         pix_q        <= '0;
         slot_q       <= '0;
         line_q       <= '0;
         vaddr_q      <= '0;
         row_base_q   <= '0;
         char_addr_q  <= '0;
         tline_q      <= '0;
         char0_q      <= '0;
         char1_q      <= '0;
         glyph0_q     <= '0;
         glyph1_q     <= '0;
         vis_q        <= 1'b0;
         pixels_o     <= '0;
         reverse_o    <= '0;
         display_en_o <= 1'b0;
         frame_o      <= 1'b0;
         underrun_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_q + 4'd1;
         frame_o <= video_latch_o && (slot_q == SlotLast) && (line_q == LineLast);
         if (video_latch_o) begin
            slot_q <= t_slot;
            line_q <= t_line;
         end
         if (slot_start) begin
            tline_q     <= t_line[2:0];
            char_addr_q <= fetch_addr;
            vis_q       <= t_vis;
            vaddr_q     <= t_vis ? fetch_addr + 11'd2 : fetch_addr;
            if (t_slot == '0) row_base_q <= new_base;
         end
         if (ack_ok) begin
            case (state_q)
               StChar0:  char0_q  <= rd_data_i;
               StChar1:  char1_q  <= rd_data_i;
               StGlyph0: glyph0_q <= rd_data_i;
               StGlyph1: glyph1_q <= rd_data_i;
               default: ;
            endcase
         end
         if (video_latch_o) begin
            if (state_q == StDone && vis_q) begin
               pixels_o     <= {glyph0_q, glyph1_q};
               reverse_o    <= {char0_q[7], char1_q[7]};
               display_en_o <= 1'b1;
            end else begin
               pixels_o     <= '0;
               reverse_o    <= '0;
               display_en_o <= 1'b0;
            end
         end
         // A miss on the same clock as a clear must win.
         underrun_o <= (video_latch_o && state_q != StDone) || (underrun_o && !underrun_clr_i);
      end
   end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Scoreboard bench for video_fetch_sched on a reduced raster (4/6 slots, 20/26 lines).
module tb_video_fetch_sched;
   localparam int unsigned HV = 4, HT = 6, VV = 20, VT = 26;
   localparam int FramePeriod = 16 * HT * VT;
   localparam int LastAddr    = 80 * ((VV - 1) / 8) + 2 * (HV - 1);

   logic        pixel_clk = 1'b0;
   logic        reset, charset, underrun_clr, rd_req, rd_space, rd_ack;
   logic [10:0] rd_addr;
   logic [7:0]  rd_data;
   logic        video_latch, display_en, frame, underrun;
   logic [15:0] pixels;
   logic [1:0]  reverse;

   video_fetch_sched #(
      .H_SLOTS_VIS(HV), .H_SLOTS_TOTAL(HT), .V_LINES_VIS(VV), .V_LINES_TOTAL(VT)
   ) dut (
      .pixel_clk_i(pixel_clk), .reset_i(reset), .charset_i(charset),
      .underrun_clr_i(underrun_clr), .rd_req_o(rd_req), .rd_space_o(rd_space),
      .rd_addr_o(rd_addr), .rd_ack_i(rd_ack), .rd_data_i(rd_data),
      .video_latch_o(video_latch), .pixels_o(pixels), .reverse_o(reverse),
      .display_en_o(display_en), .frame_o(frame), .underrun_o(underrun)
   );

   always #5 pixel_clk = ~pixel_clk;

   int errors = 0, checks = 0;
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_req"}, rd_req, 0);
      check_eq({tag, "_space"}, rd_space, 0);
      check_eq({tag, "_addr"}, rd_addr, 0);
      check_eq({tag, "_latch"}, video_latch, 0);
      check_eq({tag, "_outs"}, {pixels, reverse, display_en, frame, underrun}, 0);
   endtask

   logic [7:0]  vram [2048];
   logic [7:0]  rom  [2048];
   logic [11:0] req_q [$];
   logic [18:0] out_q [$];

   int          p, slot, line, ts, tl, req_idx, cyc, last_frame, frames;
   logic [10:0] mv, mrb, g0a, g1a;
   logic [7:0]  c0, c1;
   logic [18:0] eo;
   logic [11:0] er;
   bit          vis_cur, starve_req, starve_cur, starve_done, ack_en, mu;

   // Raster model, expected-output scoreboard and zero-wait memory responder.
   always @(negedge pixel_clk) begin
      if (reset) begin
         p = 0; slot = 0; line = 0; mv = '0; mrb = '0; req_idx = 0; vis_cur = 0;
         req_q.delete(); out_q.delete();
         rd_ack = 1'b0; rd_data = '0; ack_en = 1; starve_cur = 0; mu = 0; last_frame = -1;
      end else begin
         cyc++;
         p++;
         if (p == 16) begin
            p = 0; slot++;
            if (slot == HT) begin
               slot = 0; line++;
               if (line == VT) line = 0;
            end
         end
         check_eq("video_latch", video_latch, p == 15);
         check_eq("underrun", underrun, mu);
         check_eq("frame", frame, p == 0 && slot == 0 && line == 0);
         if (frame) begin
            if (last_frame >= 0) check_eq("frame_period", cyc - last_frame, FramePeriod);
            last_frame = cyc;
            frames++;
         end
         if (p == 0) begin
            check_eq("req_idle", rd_req, 0);
            check_eq("req_left", req_q.size(), 0);
            req_q.delete();
            if (out_q.size() > 0) begin
               eo = out_q.pop_front();
               check_eq("pixels", pixels, eo[15:0]);
               check_eq("reverse", reverse, eo[17:16]);
               check_eq("display_en", display_en, eo[18]);
            end
            if (starve_cur) starve_done = 1;
            starve_cur = 0;
            ack_en = 1;
         end
         if (p == 1) begin
            ts = (slot == HT - 1) ? 0 : slot + 1;
            tl = (slot == HT - 1) ? ((line == VT - 1) ? 0 : line + 1) : line;
            vis_cur = (ts < HV) && (tl < VV);
            req_idx = 0;
            if (ts == 0) begin
               mrb = (tl == 0) ? 11'd0 : ((tl % 8 == 0) ? mrb + 11'd80 : mrb);
               mv = mrb;
            end
            if (!vis_cur) begin
               out_q.push_back('0);
            end else if (starve_req) begin
               starve_req = 0; starve_cur = 1; ack_en = 0;
               out_q.push_back('0);
            end else begin
               c0 = vram[mv]; c1 = vram[11'(mv + 1)];
               g0a = {charset, c0[6:0], tl[2:0]};
               g1a = {charset, c1[6:0], tl[2:0]};
               req_q.push_back({1'b0, mv});
               req_q.push_back({1'b0, 11'(mv + 1)});
               req_q.push_back({1'b1, g0a});
               req_q.push_back({1'b1, g1a});
               out_q.push_back({1'b1, c0[7], c1[7], rom[g0a], rom[g1a]});
            end
            if (vis_cur) mv = mv + 11'd2;
         end
         rd_ack = 1'b0;
         if (rd_req && ack_en) begin
            if (req_q.size() == 0) begin
               check_eq("spurious_req", rd_req, 0);
            end else begin
               er = req_q.pop_front();
               check_eq("rd_space", rd_space, er[11]);
               check_eq("rd_addr", rd_addr, er[10:0]);
               if (req_idx == 0 && ts == 0 && tl == 8) check_eq("line8_addr", rd_addr, 80);
               if (req_idx < 2 && ts == HV - 1 && tl == VV - 1)
                  check_eq("last_vis_addr", rd_addr, LastAddr + req_idx);
               rd_ack = 1'b1;
               rd_data = rd_space ? rom[rd_addr] : vram[rd_addr];
               req_idx++;
            end
         end
         mu = (p == 15 && starve_cur) || (mu && !underrun_clr);
      end
   end

   bit prev, found;

   initial begin
      reset = 1'b1; charset = 1'b0; underrun_clr = 1'b0; rd_ack = 1'b0; rd_data = '0;
      starve_req = 0; starve_done = 0; frames = 0; cyc = 0;
      for (int i = 0; i < 2048; i++) begin
         vram[i] = 8'($urandom);
         rom[i]  = 8'($urandom);
      end
      vram[0] = 8'h81; vram[1] = 8'h02;
      rom[11'h008] = 8'hF0;
      rom[11'h010] = 8'h3C;

      repeat (3) @(negedge pixel_clk);
      check_reset("reset");
      #1 reset = 1'b0;
      repeat (16) @(posedge pixel_clk);
      @(negedge pixel_clk);
      check_eq("first_pixels", pixels, 16'hF03C);
      check_eq("first_reverse", reverse, 2'b10);
      check_eq("first_en", display_en, 1);

      for (int n = 0; n < 3 * FramePeriod && frames < 2; n++) @(negedge pixel_clk);
      check_eq("frames_seen", frames, 2);

      // Starve one visible slot, then clear the sticky flag.
      @(posedge pixel_clk); #1 starve_req = 1;
      for (int n = 0; n < 2000 && !starve_done; n++) @(negedge pixel_clk);
      check_eq("starve_done", starve_done, 1);
      check_eq("underrun_set", underrun, 1);
      @(posedge pixel_clk); #1 underrun_clr = 1'b1;
      @(posedge pixel_clk); #1 underrun_clr = 1'b0;
      @(negedge pixel_clk);
      check_eq("underrun_clr", underrun, 0);

      // Miss while clear is held: the set must win on the latch clock.
      starve_done = 0;
      @(posedge pixel_clk); #1 underrun_clr = 1'b1; starve_req = 1;
      for (int n = 0; n < 2000 && !starve_done; n++) @(negedge pixel_clk);
      check_eq("starve2_done", starve_done, 1);
      @(posedge pixel_clk); #1 underrun_clr = 1'b0;
      repeat (40) @(negedge pixel_clk);

      // Asynchronous reset in the middle of the first glyph request.
      prev = 0; found = 0;
      for (int n = 0; n < 2000 && !found; n++) begin
         @(negedge pixel_clk); #1;
         if (rd_req && rd_space && !prev) found = 1;
         prev = rd_req && rd_space;
      end
      check_eq("glyph0_found", found, 1);
      reset = 1'b1;
      #1 check_reset("mid_reset");
      repeat (3) @(negedge pixel_clk);
      #1 reset = 1'b0;
      repeat (16) @(posedge pixel_clk);
      @(negedge pixel_clk);
      check_eq("restart_pixels", pixels, 16'hF03C);
      check_eq("restart_reverse", reverse, 2'b10);
      check_eq("restart_en", display_en, 1);
      repeat (400) @(negedge pixel_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/video_fetch_sched.md
VIDEO_FETCH_SCHED -- requirements
Module: video_fetch_sched

Interface
REQ-001 SHALL have parameter H_SLOTS_VIS, default 40, meaning visible 16-pixel slots per scanline (2 chars each, 80 columns).
REQ-002 SHALL have parameter H_SLOTS_TOTAL, default 50, meaning total slots per scanline, visible plus blank.
REQ-003 SHALL have parameter V_LINES_VIS, default 200, meaning visible scanlines (25 char rows x 8).
REQ-004 SHALL have parameter V_LINES_TOTAL, default 260, meaning total scanlines per frame.
REQ-005 SHALL have ports: pixel_clk_i  in  1  sole clock; reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: charset_i  in  1  char ROM bank select; underrun_clr_i  in  1  clears underrun_o.
REQ-007 SHALL have ports: rd_req_o  out  1  read request; rd_space_o  out  1  0=VRAM, 1=char ROM; rd_addr_o  out  11  read address.
REQ-008 SHALL have ports: rd_ack_i  in  1  one-cycle grant, data valid same cycle; rd_data_i  in  8  read data.
REQ-009 SHALL have ports: video_latch_o  out  1  dot generator load strobe; pixels_o  out  16  slot pixels, MSB first; reverse_o  out  2  per-char invert, [1]=left char, [0]=right char; display_en_o  out  1  slot visible.
REQ-010 SHALL have ports: frame_o  out  1  one-cycle frame-wrap pulse; underrun_o  out  1  sticky fetch-miss flag.

Function
REQ-011 SHALL keep a 4-bit pixel counter incrementing each clock, wrapping 15->0; video_latch_o SHALL be high exactly when counter==15.
REQ-012 SHALL keep a slot counter (0..H_SLOTS_TOTAL-1), advanced on counter wrap; wrap of slot increments scanline (0..V_LINES_TOTAL-1); scanline wrap pulses frame_o for one clock coincident with the first clock of slot 0 / line 0.
REQ-013 At counter==0, SHALL compute the target (next) slot/scanline; target visible iff slot<H_SLOTS_VIS and line<V_LINES_VIS.
REQ-014 FSM states: IDLE, CHAR0, CHAR1, GLYPH0, GLYPH1, DONE; from IDLE at counter==0 go CHAR0 if target visible, else DONE with pixels 0, reverse 0, enable 0.
REQ-015 CHAR0/CHAR1 SHALL read VRAM (rd_space_o=0) at vaddr and vaddr+1; GLYPH0/GLYPH1 read char ROM (rd_space_o=1) at {charset_i, char[6:0], line[2:0]}.
REQ-016 Each state SHALL hold rd_req_o, rd_space_o, rd_addr_o stable until rd_ack_i, capture rd_data_i on that same clock, then advance; GLYPH1 ack -> DONE.
REQ-017 Char bit 7 SHALL become the reverse bit of that char; glyph0 fills pixels[15:8], glyph1 pixels[7:0].
REQ-018 vaddr SHALL be a running 11-bit register, +2 per visible slot fetched, reloaded from row base at each scanline start; row base +80 after line[2:0]==7, reset to 0 on frame wrap; no multiplier.
REQ-019 On counter==15: if DONE, pixels_o/reverse_o/display_en_o SHALL load assembled values; if any other state (underrun), SHALL load 0/0/0, set underrun_o, drop rd_req_o that clock without ack, return to IDLE.
REQ-020 pixels_o, reverse_o, display_en_o SHALL be registered and change only on the clock after video_latch_o high, holding for the whole slot.
REQ-021 underrun_o SHALL set on underrun; underrun_clr_i clears; simultaneous set and clear SHALL leave it set.
REQ-022 rd_ack_i while rd_req_o low SHALL be ignored.

Reset
REQ-023 reset_i high SHALL immediately force all outputs 0, counters 0, vaddr/row base 0, FSM IDLE, including mid-request (rd_req_o drops asynchronously).
REQ-024 After release, first video_latch_o SHALL occur on the 16th clock edge; fetch starts at counter==0 of slot 0.

Verification
REQ-025 Reset release, ack every request next clock, VRAM[0]=0x81, VRAM[1]=0x02, ROM[{0,0x01,0}]=0xF0, ROM[{0,0x02,0}]=0x3C -> first visible latch loads pixels 0xF03C, reverse 2'b10, enable 1.
REQ-026 Zero-wait ack -> exactly 4 requests per visible slot, 0 in blank slots, addresses 0,1 then glyphs; underrun_o stays 0 for a full frame.
REQ-027 Withhold rd_ack_i for 16 clocks -> latch loads 0/0/0, underrun_o=1, rd_req_o low next clock; underrun_clr_i with no new miss -> 0.
REQ-028 Run to line 8 -> first VRAM address on that line is 80; line 199 last slot fetches 1998/1999; line 200 issues no requests.
REQ-029 Count clocks between frame_o pulses -> 16*H_SLOTS_TOTAL*V_LINES_TOTAL = 208000.
REQ-030 Assert reset_i while rd_req_o high in GLYPH0 -> rd_req_o low without clock edge; restart identical to REQ-025.
